branch_resolve: RTL
===================

# branch_resolve

Resolution-side partner of the 2-bit saturating-counter predictor (`sat_count`). It records each prediction issued at fetch in an in-order queue. When the actual branch outcome arrives from execute, it pops the oldest entry and compares it with the outcome. It then drives the predictor's training inputs (`branch`, `taken`), raises a one-cycle mispredict/flush pulse that discards younger wrong-path predictions, and keeps branch and mispredict statistics.

## Interface
Parameters:
- DEPTH, 4, prediction queue entries; power of two, ≥ 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pred_valid  in  1  fetch issues a predicted branch this cycle.
- pred_taken  in  1  prediction value; connects to `sat_count.prediction`.
- res_valid  in  1  execute resolves the oldest outstanding branch this cycle.
- res_taken  in  1  actual outcome.
- pred_ready  out  1  `!full || pop`; the push is accepted when `pred_valid && pred_ready`.
- full  out  1  queue holds DEPTH entries (combinational from occupancy).
- empty  out  1  queue holds 0 entries (combinational).
- upd_branch  out  1  registered; drives `sat_count.branch`.
- upd_taken  out  1  registered; drives `sat_count.taken`.
- mispredict  out  1  registered one-cycle flush pulse.
- underflow  out  1  registered one-cycle pulse for `res_valid` while empty.
- branch_count  out  CNT_W  resolved branches, saturating.
- mispredict_count  out  CNT_W  mispredictions, saturating.

## Operation
- Storage:
  - DEPTH×1-bit circular queue, read/write pointers of log2(DEPTH) bits, occupancy counter of log2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
- pop = `res_valid && !empty`. A pop consumes head entry `h`.
- push = `pred_valid && pred_ready`.
  - When full, a push is accepted only in a cycle that also pops.
  - If that pop mispredicts, the push is still dropped (see flush).
- Resolution on a pop:
  - upd_branch ← 1, upd_taken ← res_taken. These are the training inputs for the predictor, one update per resolved branch.
  - If `h != res_taken`: mispredict ← 1; mispredict_count += 1 (saturating at 2^CNT_W−1).
  - branch_count += 1 (saturating).
- Flush on a mispredict:
  - In the same edge, the whole queue is cleared: occupancy 0, read pointer = write pointer.
  - Any push presented in that cycle is discarded, because it is a wrong-path prediction.
- No pop: upd_branch ← 0, upd_taken ← 0, mispredict ← 0.
- `res_valid` while empty:
  - No pop, no update, counters unchanged.
  - underflow ← 1 for one cycle.
  - A push in that cycle proceeds normally.
- Simultaneous push and pop without a mispredict: occupancy is unchanged and both pointers advance. This is legal even when full or when occupancy is 1.
- Reset (any cycle, including mid-queue or during a mispredict pulse):
  - Occupancy, pointers, counters → 0.
  - upd_branch, upd_taken, mispredict, underflow → 0.
  - empty = 1, full = 0, pred_ready = 1.
  - Inputs presented in the reset cycle are ignored.

## Timing
- A push at edge N is poppable from cycle N+1.
  - Fall-through within the same cycle is not supported: a push and pop in one cycle on an empty queue yields underflow.
- Resolution latency is 1 cycle. For `res_valid` sampled at edge N:
  - upd_*, mispredict and underflow are valid during cycle N..N+1 (after edge N).
  - The counters reflect the increment after edge N.
- `empty` is 1 in the cycle after a mispredict edge.
- Back-to-back resolutions every cycle are supported at full throughput. Each produces its own update pulse.
- full, empty and pred_ready are combinational from registered occupancy plus `res_valid`. They carry no input-to-register combinational loop.

## Test plan
- Reset:
  - Assert reset for 2 cycles with pred_valid=1.
  - Expect empty=1, full=0, all pulses 0, both counts 0, and no entry enqueued.
- Correct predictions:
  - Push taken, taken, not-taken (3 cycles).
  - Then resolve 1, 1, 0 back-to-back.
  - Expect upd_branch=1 for 3 cycles with upd_taken=1,1,0; mispredict never 1; branch_count=3; mispredict_count=0; empty=1 afterwards.
- Mispredict flush:
  - Push 1,1,1, then resolve with res_taken=0 while also pushing.
  - Expect mispredict=1 for exactly one cycle, upd_taken=0, empty=1 next cycle (the push is dropped), mispredict_count=1.
- Full boundary (DEPTH=4):
  - Push 5 predictions.
  - Expect full=1 and pred_ready=0 after 4; the 5th is rejected.
  - Then a push and a correct resolve in the same cycle: push accepted, full stays 1.
- Underflow:
  - res_valid=1 with the queue empty.
  - Expect underflow=1 for one cycle, upd_branch=0, counters unchanged.
- Saturation:
  - With CNT_W=2, resolve 5 mispredicting branches.
  - Expect branch_count=3 and mispredict_count=3; both hold at 3.
  - Then reset mid-stream → both counts 0.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: resolution-side partner of the 2-bit saturating-counter
// predictor. Queues fetch-time predictions in order, and compares the oldest
// one against the execute outcome. It emits training updates and a flush
// pulse, and keeps saturating branch and mispredict statistics.
module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             pred_ready,
  output logic             full,
  output logic             empty,
  output logic             upd_branch,
  output logic             upd_taken,
  output logic             mispredict,
  output logic             underflow,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      occ;
  logic [AW:0]      occ_next;
  logic             head;
  logic             pop;
  logic             push;
  logic             mis;

  // Queue status and handshake, derived only from registered occupancy and res_valid
  always_comb begin
    full       = (occ == FULL_OCC);
    empty      = (occ == '0);
    pop        = res_valid && !empty;
    pred_ready = !full || pop;
    push       = pred_valid && pred_ready;
    head       = mem[rd_ptr];
    mis        = pop && (head != res_taken);
  end

  // Occupancy after this edge when no flush occurs; push and pop together leave it unchanged
  always_comb begin
    occ_next = occ;
    unique case ({push, pop})
      2'b10:   occ_next = occ + (AW+1)'(1);
      2'b01:   occ_next = occ - (AW+1)'(1);
      default: occ_next = occ;
    endcase
  end

  // Prediction storage; a push in a mispredict cycle is a wrong-path prediction and is dropped
  always_ff @(posedge clk) begin
    if (!reset && push && !mis) begin
      mem[wr_ptr] <= pred_taken;
    end
  end

  // Pointers and occupancy; a mispredict empties the queue by snapping the read pointer to the write pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (mis) begin
      rd_ptr <= wr_ptr;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ <= occ_next;
    end
  end

  // Registered training update, flush pulse and underflow pulse, one cycle after resolution
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_branch <= 1'b0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      upd_branch <= pop;
      upd_taken  <= pop && res_taken;
      mispredict <= mis;
      underflow  <= res_valid && empty;
    end
  end

  // Saturating statistics; they hold at all-ones so long runs never wrap to a misleading small value
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop && (branch_count != CNT_MAX)) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mis && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule
